// File: rtl/rr_mux_sel_arbiter.sv
// Round-robin arbiter that shares one 8:1 mux among 8 requesters.
// A grant lasts while its owner keeps requesting, capped at MAX_HOLD cycles.
// The owner's index drives the mux select. All outputs come from registers.
module rr_mux_sel_arbiter #(
  parameter int MAX_HOLD = 4,  // legal range 1..15
  parameter int HOLD_W   = 4   // 2**HOLD_W must exceed MAX_HOLD
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] req,
  output logic [2:0] s,
  output logic [7:0] gnt,
  output logic       gnt_valid,
  output logic       gnt_new
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [7:0]        r_gnt,   w_gnt_nxt;
  logic [2:0]        r_s,     w_s_nxt;
  logic [2:0]        r_last,  w_last_nxt;
  logic [HOLD_W-1:0] r_hold,  w_hold_nxt;
  logic              r_new,   w_new_nxt;

  logic [2:0]        w_pick;
  logic              w_any_req;
  logic              w_release;

  // Returns the first requesting index after base. The search runs
  // base+1, base+2, ... and wraps round, so base itself is tried last.
  function automatic logic [2:0] rr_pick(input logic [7:0] rq, input logic [2:0] base);
    logic [2:0] idx;
    logic [2:0] win;
    logic       found;
    win   = base;
    found = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      idx = base + 3'(k);
      if (!found && rq[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

  // In BUSY, r_last equals the owner. One search base therefore covers both states.
  // In BUSY, the owner gets lowest priority.
  assign w_any_req = |req;
  assign w_pick    = rr_pick(req, r_last);
  assign w_release = !en || !req[r_s] || (r_hold == HOLD_W'(MAX_HOLD));

  // Next-state and next-output decode for the IDLE/BUSY grant FSM
  always_comb begin
    // NOTE: every signal gets a default before any branch. A path that skips an assignment would infer a latch.
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_s_nxt     = r_s;
    w_last_nxt  = r_last;
    w_hold_nxt  = r_hold;
    w_new_nxt   = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (en && w_any_req) begin
          w_state_nxt = BUSY;
          w_gnt_nxt   = 8'b1 << w_pick;
          w_s_nxt     = w_pick;
          w_last_nxt  = w_pick;
          w_hold_nxt  = HOLD_W'(1);
          w_new_nxt   = 1'b1;
        end
      end
      BUSY: begin
        if (!w_release) begin
          w_hold_nxt = r_hold + 1'b1;
        end else if (en && w_any_req) begin
          // Re-arbitrate on the releasing edge, so no dead cycle is inserted.
          w_gnt_nxt  = 8'b1 << w_pick;
          w_s_nxt    = w_pick;
          w_last_nxt = w_pick;
          w_hold_nxt = HOLD_W'(1);
          w_new_nxt  = 1'b1;
        end else begin
          // s and last keep the previous owner's index.
          w_state_nxt = IDLE;
          w_gnt_nxt   = 8'h00;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = 8'h00;
      end
    endcase
  end

  // State and output registers. Reset is asynchronous and parks last at 7, so requester 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_gnt   <= 8'h00;
      r_s     <= 3'd0;
      r_last  <= 3'd7;
      r_hold  <= '0;
      r_new   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments. Every register then samples the pre-edge values.
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_s     <= w_s_nxt;
      r_last  <= w_last_nxt;
      r_hold  <= w_hold_nxt;
      r_new   <= w_new_nxt;
    end
  end

  assign s         = r_s;
  assign gnt       = r_gnt;
  assign gnt_valid = |r_gnt;
  assign gnt_new   = r_new;

endmodule

// File: tb/tb_rr_mux_sel_arbiter.sv
// Self-checking bench for rr_mux_sel_arbiter.
// Two instances share the stimulus: MAX_HOLD=4 and MAX_HOLD=1.
// A behavioural reference model follows the arbitration rules, keeping the owner as an integer.
// Directed scenarios come first, then randomized traffic.
module tb_rr_mux_sel_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] req;

  logic [2:0] s_a, s_b;
  logic [7:0] gnt_a, gnt_b;
  logic       gv_a, gv_b, gn_a, gn_b;

  int g_tests = 0;
  int g_fails = 0;

  typedef struct {
    int owner;  // -1 when idle
    int last;
    int hold;
    int s;
    bit newp;
  } mstate_t;

  mstate_t ma, mb;

  rr_mux_sel_arbiter #(.MAX_HOLD(4), .HOLD_W(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .s(s_a), .gnt(gnt_a), .gnt_valid(gv_a), .gnt_new(gn_a)
  );

  rr_mux_sel_arbiter #(.MAX_HOLD(1), .HOLD_W(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .s(s_b), .gnt(gnt_b), .gnt_valid(gv_b), .gnt_new(gn_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    g_tests++;
    if (obs !== exp) begin
      g_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic mstate_t mreset();
    mstate_t m;
    m.owner = -1;
    m.last  = 7;
    m.hold  = 0;
    m.s     = 0;
    m.newp  = 1'b0;
    return m;
  endfunction

  // One clock edge of the reference model.
  function automatic mstate_t mstep(mstate_t m, logic [7:0] rq, logic e, int mh);
    mstate_t n;
    bit      rel;
    bit      done;
    n      = m;
    n.newp = 1'b0;
    if (m.owner < 0) rel = 1'b1;
    else             rel = !e || !rq[m.owner] || (m.hold == mh);
    if (!rel) begin
      n.hold = m.hold + 1;
    end else if (e && rq != 8'h00) begin
      done = 1'b0;
      for (int k = 1; k <= 8; k++) begin
        if (!done && rq[(m.last + k) % 8]) begin
          done    = 1'b1;
          n.owner = (m.last + k) % 8;
          n.s     = n.owner;
          n.last  = n.owner;
          n.hold  = 1;
          n.newp  = 1'b1;
        end
      end
    end else begin
      n.owner = -1;
    end
    return n;
  endfunction

  function automatic logic [7:0] exp_gnt(mstate_t m);
    return (m.owner < 0) ? 8'h00 : (8'h01 << m.owner);
  endfunction

  task automatic compare_all();
    check("a.gnt",       gnt_a, exp_gnt(ma));
    check("a.s",         s_a,   ma.s);
    check("a.gnt_valid", gv_a,  ma.owner >= 0);
    check("a.gnt_new",   gn_a,  ma.newp);
    check("b.gnt",       gnt_b, exp_gnt(mb));
    check("b.s",         s_b,   mb.s);
    check("b.gnt_valid", gv_b,  mb.owner >= 0);
    check("b.gnt_new",   gn_b,  mb.newp);
  endtask

  // Drives the inputs, advances one rising edge and the model, then samples 1 ns later.
  task automatic step(input logic [7:0] rq, input logic e);
    req = rq;
    en  = e;
    @(posedge clk);
    if (rst_n) begin
      ma = mstep(ma, rq, e, 4);
      mb = mstep(mb, rq, e, 1);
    end else begin
      ma = mreset();
      mb = mreset();
    end
    #1;
    compare_all();
  endtask

  // Asserts reset between clock edges and checks its effect with no edge in between.
  task automatic async_reset();
    rst_n = 1'b0;
    ma = mreset();
    mb = mreset();
    #1;
    compare_all();
    check("rst.gnt_imm", gnt_a, 8'h00);
    check("rst.s_imm",   s_a,   3'd0);
    rst_n = 1'b1;
  endtask

  int n_new;
  int n_idle;

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    req   = 8'hFF;
    ma    = mreset();
    mb    = mreset();

    // Reset held with full requests, then released.
    for (int i = 0; i < 3; i++) step(8'hFF, 1'b1);
    check("reset.gnt", gnt_a, 8'h00);
    check("reset.gv",  gv_a,  1'b0);
    #2 rst_n = 1'b1;
    step(8'hFF, 1'b1);
    check("first.gnt", gnt_a, 8'h01);
    check("first.s",   s_a,   3'd0);

    // A single requester gets re-granted on every hold expiry.
    async_reset();
    n_new = 0;
    for (int i = 0; i < 12; i++) begin
      step(8'h20, 1'b1);
      check("single.gnt", gnt_a, 8'h20);
      if (gn_a) n_new++;
    end
    check("single.new_count", n_new, 3);

    // Fairness: with full requests, each index holds for exactly 4 cycles.
    async_reset();
    n_idle = 0;
    for (int i = 0; i < 36; i++) begin
      step(8'hFF, 1'b1);
      check("fair.s", s_a, (i / 4) % 8);
      if (!gv_a) n_idle++;
    end
    check("fair.idle_cycles", n_idle, 0);

    // Early release hands over with no idle cycle, then goes idle.
    async_reset();
    step(8'h44, 1'b1);
    check("early.gnt0", gnt_a, 8'h04);
    step(8'h44, 1'b1);
    step(8'h40, 1'b1);
    check("early.gnt1", gnt_a, 8'h40);
    check("early.new1", gn_a,  1'b1);
    step(8'h00, 1'b1);
    check("early.gnt2", gnt_a, 8'h00);
    check("early.s2",   s_a,   3'd6);

    // Dropping enable forces a release; re-enabling resumes after the last owner.
    async_reset();
    step(8'h18, 1'b1);
    check("en.gnt0", gnt_a, 8'h08);
    step(8'h18, 1'b0);
    check("en.gnt1", gnt_a, 8'h00);
    step(8'h18, 1'b1);
    check("en.gnt2", gnt_a, 8'h10);

    // Asynchronous reset arrives in the middle of a grant.
    async_reset();
    step(8'h80, 1'b1);
    check("amid.gnt0", gnt_a, 8'h80);
    async_reset();
    step(8'h81, 1'b1);
    check("amid.gnt1", gnt_a, 8'h01);

    // Randomized traffic with sparse and dense request patterns, plus occasional enable drops and resets.
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] rq;
      case ($urandom_range(0, 3))
        0:       rq = 8'($urandom) & 8'($urandom) & 8'($urandom);
        1:       rq = 8'($urandom) | 8'($urandom);
        2:       rq = 8'h01 << $urandom_range(0, 7);
        default: rq = 8'($urandom);
      endcase
      if ($urandom_range(0, 299) == 0) async_reset();
      step(rq, $urandom_range(0, 9) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", g_tests, g_fails);
    $finish;
  end

endmodule

// File: doc/rr_mux_sel_arbiter.md
Name: rr_mux_sel_arbiter

Overview:
- Round-robin arbiter that shares one 8:1 mux (8 data bits `i`, 3-bit select `s`, output `Y`) among 8 requesters.
- Grants one requester at a time. Drives the mux select with the owner's index and returns a one-hot grant.
- A grant lasts while the owner keeps requesting, capped at MAX_HOLD cycles, so no requester starves.

Parameters:
- MAX_HOLD, 4, maximum consecutive cycles per grant; legal range 1..15.
- HOLD_W, 4, width of the hold counter; must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  arbitration enable; low forces release and blocks new grants.
- req  input  8  request vector; req[k] high means requester k wants mux input k routed to Y.
- s  output  3  mux select (registered); index of current/last owner.
- gnt  output  8  one-hot grant (registered); all-zero when idle.
- gnt_valid  output  1  high while gnt is non-zero.
- gnt_new  output  1  one-cycle pulse on every cycle a grant is (re)issued.

Behaviour:
- Reset (async, rst_n=0): immediately, without a clock edge, s=0, gnt=0, gnt_valid=0, gnt_new=0, state=IDLE, hold_cnt=0, last=7. With last=7, requester 0 has top priority after reset.
- States: IDLE, BUSY. owner = index of the set bit in gnt.
- Round-robin pick: search indices last+1, last+2, … mod 8, including last itself as the final candidate. The first index with req set wins.
- IDLE:
  - If en=1 and |req=1, next edge: gnt=onehot(pick), s=pick, gnt_valid=1, gnt_new=1, last=pick, hold_cnt=1, state→BUSY.
  - Request-to-grant latency is 1 cycle.
  - Otherwise remain IDLE; s holds its previous value.
- BUSY, release condition: en=0, or req[owner]=0, or hold_cnt==MAX_HOLD.
- BUSY, no release: gnt and s hold, hold_cnt+1, gnt_new=0.
- BUSY, release with en=1 and |req=1: re-arbitrate on the same edge, no dead cycle.
  - New pick starts after the current owner, so the owner has lowest priority.
  - Owner is re-granted only if it is the sole requester and still requesting (hold expiry); gnt_new pulses again, hold_cnt=1.
- BUSY, release otherwise: gnt=0, gnt_valid=0, state→IDLE. s keeps the last owner index; last is unchanged.
- Dropped request: gnt clears one edge after the owner drops req. The owner sees a single stale grant cycle and must tolerate it.
- en=0 in any state: gnt=0 on the next edge, state→IDLE. en has no effect on s or last.
- MAX_HOLD=1: every BUSY cycle is a release, giving strict one-cycle round-robin.
- Req bits outside the winning index never alter the current grant mid-hold.
- Invariants: gnt is zero or one-hot; gnt_valid == |gnt; when gnt_valid=1, gnt == (1<<s).
- Implementation uses registered outputs only; no combinational path from req to gnt.

Test Plan:
- Reset: rst_n=0 with req=8'hFF, en=1 for 3 edges → gnt=0, s=0, gnt_valid=0, gnt_new=0. Release reset → next edge gnt=8'h01, s=0.
- Single requester: req=8'h20 held 12 cycles, MAX_HOLD=4 → from edge 1 gnt=8'h20 and s=5 continuously; gnt_new pulses on edges 1, 5, 9.
- Fairness: req=8'hFF held, MAX_HOLD=4 → s sequence 0,1,2,…,7,0, each value held exactly 4 cycles; gnt_new every 4th edge; gnt_valid never drops.
- Early release: req=8'h44 → gnt=8'h04; drop req[2] after 2 grant cycles → next edge gnt=8'h40, s=6, gnt_new=1, no idle cycle. Drop req[6] → next edge gnt=0, s stays 6.
- Enable: grant to requester 3 with req=8'h18; deassert en → next edge gnt=0, IDLE. Reassert en → next edge gnt=8'h10 (index after last=3).
- Async reset mid-grant: assert rst_n=0 between edges while gnt=8'h80 → gnt=0, s=0 immediately. Release with req=8'h81 → gnt=8'h01.
